// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular reorder buffer for the Tomasulo core. It allocates
//                tags at issue, captures CDB results, answers operand-tag
//                queries with same-cycle CDB forwarding, and commits in
//                program order. Stores go to the LS queue. A taken branch
//                flushes the buffer and redirects fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // allocation from the decoder
    input  logic                  in_alloc_ena,
    input  logic [REG_WIDTH-1:0]  in_alloc_rd,
    input  logic [1:0]            in_alloc_kind,
    output logic [ROB_WIDTH-1:0]  out_alloc_tag,
    output logic                  out_full,
    // operand queries
    input  logic [ROB_WIDTH-1:0]  in_query_tag1,
    input  logic [ROB_WIDTH-1:0]  in_query_tag2,
    output logic                  out_tag1_ready,
    output logic                  out_tag2_ready,
    output logic [DATA_WIDTH-1:0] out_value1,
    output logic [DATA_WIDTH-1:0] out_value2,
    // common data bus
    input  logic                  in_cdb_valid,
    input  logic [ROB_WIDTH-1:0]  in_cdb_tag,
    input  logic [DATA_WIDTH-1:0] in_cdb_value,
    input  logic                  in_cdb_taken,
    input  logic [DATA_WIDTH-1:0] in_cdb_target,
    // commit to regfile
    output logic                  out_commit_ena,
    output logic [REG_WIDTH-1:0]  out_commit_rd,
    output logic [DATA_WIDTH-1:0] out_commit_value,
    output logic [ROB_WIDTH-1:0]  out_commit_tag,
    // commit to LS queue
    output logic                  out_store_ena,
    output logic [ROB_WIDTH-1:0]  out_store_tag,
    // commit to fetch
    output logic                  out_flush,
    output logic [DATA_WIDTH-1:0] out_flush_pc
);

    localparam int DEPTH = 2 ** ROB_WIDTH;

    localparam logic [ROB_WIDTH-1:0] c_PTR_FIRST = ROB_WIDTH'(1);
    localparam logic [ROB_WIDTH-1:0] c_PTR_LAST  = ROB_WIDTH'(DEPTH - 1);
    localparam logic [1:0]           c_KIND_REG    = 2'd0;
    localparam logic [1:0]           c_KIND_STORE  = 2'd1;
    localparam logic [1:0]           c_KIND_BRANCH = 2'd2;

    // per-entry state; entry 0 is never allocated (tag 0 means "no tag")
    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      r_ready;
    logic [DEPTH-1:0]      r_taken;
    logic [1:0]            r_kind   [DEPTH];
    logic [REG_WIDTH-1:0]  r_rd     [DEPTH];
    logic [DATA_WIDTH-1:0] r_value  [DEPTH];
    logic [DATA_WIDTH-1:0] r_target [DEPTH];

    logic [ROB_WIDTH-1:0]  r_head;
    logic [ROB_WIDTH-1:0]  r_tail;
    logic [ROB_WIDTH-1:0]  r_count;

    logic                  w_full;
    logic                  w_commit;
    logic                  w_flush;
    logic                  w_alloc;
    logic                  w_cdb;
    logic [1:0]            w_alloc_kind;

    // pointers skip slot 0 when wrapping
    function automatic logic [ROB_WIDTH-1:0] f_next(input logic [ROB_WIDTH-1:0] p);
        return (p == c_PTR_LAST) ? c_PTR_FIRST : p + ROB_WIDTH'(1);
    endfunction

    // control decode from current state
    always_comb begin
        w_full       = (r_count == c_PTR_LAST);
        w_commit     = (r_count != '0) && r_busy[r_head] && r_ready[r_head];
        w_flush      = w_commit && (r_kind[r_head] == c_KIND_BRANCH) && r_taken[r_head];
        // a taken-branch commit voids anything arriving in the same cycle
        w_alloc      = in_alloc_ena && !w_full && !w_flush;
        w_cdb        = in_cdb_valid && (in_cdb_tag != '0) && r_busy[in_cdb_tag] && !w_flush;
        // reserved kind behaves as a plain register write
        w_alloc_kind = (in_alloc_kind == 2'd3) ? c_KIND_REG : in_alloc_kind;
    end

    assign out_full      = w_full;
    assign out_alloc_tag = r_tail;

    // operand queries with same-cycle CDB forwarding
    always_comb begin
        out_tag1_ready = 1'b0;
        out_value1     = '0;
        out_tag2_ready = 1'b0;
        out_value2     = '0;
        if ((in_query_tag1 != '0) && r_busy[in_query_tag1]) begin
            if (in_cdb_valid && (in_cdb_tag == in_query_tag1)) begin
                out_tag1_ready = 1'b1;
                out_value1     = in_cdb_value;
            end else begin
                out_tag1_ready = r_ready[in_query_tag1];
                out_value1     = r_value[in_query_tag1];
            end
        end
        if ((in_query_tag2 != '0) && r_busy[in_query_tag2]) begin
            if (in_cdb_valid && (in_cdb_tag == in_query_tag2)) begin
                out_tag2_ready = 1'b1;
                out_value2     = in_cdb_value;
            end else begin
                out_tag2_ready = r_ready[in_query_tag2];
                out_value2     = r_value[in_query_tag2];
            end
        end
    end

    // entry state, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= c_PTR_FIRST;
            r_tail  <= c_PTR_FIRST;
            r_count <= '0;
            r_busy  <= '0;
            r_ready <= '0;
            r_taken <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_kind[i]   <= '0;
                r_rd[i]     <= '0;
                r_value[i]  <= '0;
                r_target[i] <= '0;
            end
        end else if (w_flush) begin
            r_head  <= c_PTR_FIRST;
            r_tail  <= c_PTR_FIRST;
            r_count <= '0;
            r_busy  <= '0;
            r_ready <= '0;
        end else begin
            if (w_alloc) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_taken[r_tail] <= 1'b0;
                r_kind[r_tail]  <= w_alloc_kind;
                r_rd[r_tail]    <= in_alloc_rd;
                r_value[r_tail] <= '0;
                r_tail          <= f_next(r_tail);
            end
            if (w_cdb) begin
                r_ready[in_cdb_tag]  <= 1'b1;
                r_value[in_cdb_tag]  <= in_cdb_value;
                r_taken[in_cdb_tag]  <= in_cdb_taken;
                r_target[in_cdb_tag] <= in_cdb_target;
            end
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= f_next(r_head);
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + ROB_WIDTH'(1);
                2'b01:   r_count <= r_count - ROB_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // registered commit pulses; data fields hold between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_commit_ena   <= 1'b0;
            out_commit_rd    <= '0;
            out_commit_value <= '0;
            out_commit_tag   <= '0;
            out_store_ena    <= 1'b0;
            out_store_tag    <= '0;
            out_flush        <= 1'b0;
            out_flush_pc     <= '0;
        end else begin
            out_commit_ena <= 1'b0;
            out_store_ena  <= 1'b0;
            out_flush      <= 1'b0;
            if (w_commit) begin
                case (r_kind[r_head])
                    c_KIND_STORE: begin
                        out_store_ena <= 1'b1;
                        out_store_tag <= r_head;
                    end
                    c_KIND_BRANCH: begin
                        if (r_taken[r_head]) begin
                            out_flush    <= 1'b1;
                            out_flush_pc <= r_target[r_head];
                        end
                    end
                    default: begin
                        if (r_rd[r_head] != '0) begin
                            out_commit_ena   <= 1'b1;
                            out_commit_rd    <= r_rd[r_head];
                            out_commit_value <= r_value[r_head];
                            out_commit_tag   <= r_head;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer (ROB) for the Tomasulo out-of-order core.
- Responds to the decoder's operand-tag queries: query tags in, ready flags and values out.
- Allocates a tag per issued instruction, captures CDB results, and commits in program order.
- Commit targets: the regfile, the LS queue (stores), and the fetch unit (branch flush/redirect).

Parameters:
ROB_WIDTH, 4, tag width; DEPTH = 2**ROB_WIDTH; tag 0 is reserved as "no tag", so DEPTH-1 entries are usable
DATA_WIDTH, 32, data/pc width
REG_WIDTH, 5, architectural register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_alloc_ena  in  1  decoder issues an instruction this cycle
in_alloc_rd  in  REG_WIDTH  destination register (0 = none)
in_alloc_kind  in  2  0 = reg write, 1 = store, 2 = branch, 3 = reserved (treated as 0)
out_alloc_tag  out  ROB_WIDTH  tag the next allocation receives (combinational, = tail)
out_full  out  1  no free entry; decoder must hold ena low
in_query_tag1, in_query_tag2  in  ROB_WIDTH  tags from the decoder
out_tag1_ready, out_tag2_ready  out  1  queried entry has its result
out_value1, out_value2  out  DATA_WIDTH  result of the queried entry
in_cdb_valid  in  1  CDB broadcast valid
in_cdb_tag  in  ROB_WIDTH  producing tag
in_cdb_value  in  DATA_WIDTH  result value
in_cdb_taken  in  1  branch resolved taken (branches only)
in_cdb_target  in  DATA_WIDTH  branch target (branches only)
out_commit_ena  out  1  one-cycle pulse: regfile write
out_commit_rd  out  REG_WIDTH  register to write
out_commit_value  out  DATA_WIDTH  value to write
out_commit_tag  out  ROB_WIDTH  regfile clears busy only if its tag equals this
out_store_ena  out  1  one-cycle pulse: LS queue may perform store
out_store_tag  out  ROB_WIDTH  store's tag
out_flush  out  1  one-cycle pulse: mispredict; all younger state is void
out_flush_pc  out  DATA_WIDTH  redirect target

Behaviour:
- Per-entry state: busy, ready, kind, rd, value, taken, target.
- Pointers: head, tail in 1..DEPTH-1; increment wraps DEPTH-1 -> 1, never to 0. Counter count spans 0..DEPTH-1.
- Reset (async, rst_n low): head = tail = 1; count = 0; all busy/ready cleared; every registered output 0. Reset mid-operation discards all entries immediately.
- out_full = (count == DEPTH-1), evaluated from current state. An alloc while full is ignored; a same-cycle commit does not unblock it.
- Alloc on a clock edge: entry[tail] gets busy=1, ready=0, kind, rd; tail advances.
- CDB: if in_cdb_valid and entry[in_cdb_tag] is busy, set ready=1 and capture value/taken/target. A CDB to tag 0 or to a non-busy entry is ignored.
- Query (combinational), per port:
  - tag 0 or non-busy entry: ready=0, value=0.
  - in_cdb_valid and cdb_tag == query tag: ready=1, value=in_cdb_value (same-cycle forward).
  - otherwise: ready/value from the entry.
- Commit, at most one per cycle, when count>0 and entry[head] is ready. On that edge, clear the entry's busy, advance head, and pulse for one cycle:
  - kind 0, rd != 0: out_commit_ena, rd/value/tag.
  - kind 0, rd == 0: retire silently.
  - kind 1: out_store_ena, out_store_tag.
  - kind 2, not taken: retire silently.
  - kind 2, taken: out_flush=1, out_flush_pc=target; head = tail = 1; count = 0; all busy/ready cleared. An alloc or CDB in the same cycle is dropped.
- Latency: a CDB in cycle N lets the entry commit at the edge ending cycle N+1; pulses are visible in cycle N+2.
- Simultaneous alloc and commit: count unchanged, both pointers advance.
- Commit outputs are registered. Non-pulsed data fields hold their last value; enables return to 0.

Test Plan:
- Reset, then 3 allocs (rd=5,6,7, kind 0) -> tags 1, 2, 3. CDB tag2=0xBB then tag1=0xAA -> commits rd5=0xAA then rd6=0xBB on consecutive cycles; tag3 is held.
- Query tag2 in the same cycle as CDB tag2=0x1234 -> out_tag1_ready=1, out_value1=0x1234. Query tag 0 -> ready 0, value 0.
- Alloc 15 entries -> out_full=1 and a 16th alloc is ignored. Commit all 15 -> head wraps 15 -> 1 and the next allocated tag is 1.
- Store at tag1 ready -> out_store_ena pulse with tag 1 and no out_commit_ena.
- Branch tag1 taken with target 0x100, younger tags 2 and 3 allocated -> out_flush=1, flush_pc=0x100, out_alloc_tag=1, count 0, and the tag2 query returns ready=0.
- Drop rst_n with 4 busy entries -> all outputs 0 immediately and out_alloc_tag=1.
